ads9327_conv_scheduler: RTL and testbench
=========================================

ADS9327_CONV_SCHEDULER -- requirements
Module: ads9327_conv_scheduler

Interface
REQ-001 The module SHALL have parameter CONV_HIGH_CYC, default 4, giving the CONVST high width in clk cycles (1..15).
REQ-002 The module SHALL have parameter CONV_WAIT_CYC, default 16, giving the clk cycles from CONVST fall to readout start (1..31).
REQ-003 The module SHALL have parameter READ_CYC, default 32, giving the readout window length in clk cycles (1..63).
REQ-004 The module SHALL have parameter CNT_W, default 16, giving the width of the frame counter.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port start, input, 1 bit: one-cycle request to begin continuous conversions.
REQ-008 The module SHALL have port stop, input, 1 bit: one-cycle request to end conversions after the current frame.
REQ-009 The module SHALL have port rate_sel, input, 3 bits: conversion period select, period = 2^(rate_sel+6) clk cycles.
REQ-010 The module SHALL have port convst, output, 1 bit: ADC conversion-start strobe.
REQ-011 The module SHALL have port rd_en, output, 1 bit: readout-window enable for the data capture path.
REQ-012 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse on the last cycle of each readout window.
REQ-014 The module SHALL have port sample_cnt, output, CNT_W bits: count of completed frames.
REQ-015 The module SHALL have port overrun, output, 1 bit: sticky flag set when a period tick is missed.

Function
REQ-016 The module SHALL run a free-running 13-bit tick counter; a tick occurs when the low (rate_sel_q+6) counter bits are all zero.
REQ-017 The module SHALL latch rate_sel into rate_sel_q only on an accepted start; changes to rate_sel at any other time have no effect.
REQ-018 The module SHALL use the states IDLE, WAIT_TICK, CONV, GAP and READ.
REQ-019 In IDLE, the module SHALL accept start with stop low: it moves to WAIT_TICK on the next cycle, clears overrun and clears sample_cnt.
REQ-020 In WAIT_TICK, on a tick the module SHALL enter CONV, holding convst high for exactly CONV_HIGH_CYC cycles.
REQ-021 After CONV, the module SHALL spend exactly CONV_WAIT_CYC cycles in GAP with convst and rd_en low.
REQ-022 After GAP, the module SHALL spend exactly READ_CYC cycles in READ with rd_en high.
REQ-023 On the last READ cycle, the module SHALL assert frame_done and increment sample_cnt, wrapping from all-ones to zero.
REQ-024 After READ, the module SHALL go to WAIT_TICK, or to IDLE if a stop is pending.
REQ-025 A stop received in WAIT_TICK SHALL return the module to IDLE on the next cycle.
REQ-026 A stop received in CONV, GAP or READ SHALL be held pending; the current frame completes and is never truncated.
REQ-027 A start received while busy SHALL be ignored.
REQ-028 When start and stop arrive in the same IDLE cycle, stop SHALL win and the module SHALL remain in IDLE.
REQ-029 A tick that occurs in CONV, GAP or READ SHALL set overrun and be dropped, with no queued frame.
REQ-030 The sequencing logic SHALL treat CONV_HIGH_CYC+CONV_WAIT_CYC+READ_CYC <= 63 as a design precondition; with defaults (52) no overrun can occur.
REQ-031 The outputs convst, rd_en and frame_done SHALL be registered and glitch-free.

Reset
REQ-032 While rst is high at a clk edge, the module SHALL enter IDLE; convst, rd_en, busy, frame_done and overrun SHALL be 0, and sample_cnt, the tick counter, rate_sel_q and any pending stop SHALL be cleared.
REQ-033 A reset asserted mid-frame SHALL abort the frame immediately, with convst and rd_en low on the cycle after the reset edge.

Configuration
REQ-034 When ADS9327_SCHED_BURST_EN is defined, the module SHALL add input burst_len[7:0], sampled on an accepted start.
REQ-035 With ADS9327_SCHED_BURST_EN defined and burst_len nonzero, the module SHALL return to IDLE after burst_len frames; burst_len=0 means continuous operation.
REQ-036 When ADS9327_SCHED_BURST_EN is undefined, the burst_len port SHALL be absent and operation SHALL always be continuous until stop.

Verification
REQ-037 The bench SHALL check: rate_sel=0, start -> convst high for 4 cycles every 64 cycles, rd_en high 32 cycles starting 20 cycles after each convst rise, sample_cnt increments by 1 per frame.
REQ-038 The bench SHALL check: stop during READ of frame 3 -> frame 3 completes, frame_done pulses, busy falls the next cycle, sample_cnt=3.
REQ-039 The bench SHALL check: start and stop in the same IDLE cycle -> busy stays 0 and convst never rises.
REQ-040 The bench SHALL check: parameters 15/31/63 with rate_sel=0 -> overrun=1 after the first dropped tick, and it stays set until the next start.
REQ-041 The bench SHALL check: rst pulse during GAP -> all outputs 0 the following cycle, and a new start behaves as from power-up.
REQ-042 The bench SHALL check: with ADS9327_SCHED_BURST_EN defined and burst_len=5 -> exactly 5 frame_done pulses, then IDLE, sample_cnt=5.

Source files
------------

// File: rtl/ads9327_conv_scheduler.sv
// ads9327_conv_scheduler
// Paces ADS9327 conversions. A free-running 13-bit tick counter marks
// conversion periods of 2^(rate_sel+6) clk cycles. Each period starts one
// frame: CONVST high, a wait gap, then a readout window for the capture path.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle request to begin continuous conversions (idle only)
//   stop         one-cycle request to end after the current frame
//   rate_sel     period select, latched on an accepted start
//   burst_len    frames per burst, 0 = continuous (ADS9327_SCHED_BURST_EN only)
//   convst       conversion-start strobe (registered)
//   rd_en        readout-window enable (registered)
//   busy         high whenever the scheduler is not idle
//   frame_done   one-cycle pulse on the last readout cycle (registered)
//   sample_cnt   completed-frame count, wraps
//   overrun      sticky: a period tick arrived while a frame was in flight
//   dbg_state_o  current FSM state for checkers
//
// Optional feature: define ADS9327_SCHED_BURST_EN to add burst_len.
//
// Handshake: start/stop are single-cycle strobes with no ready; start is
// accepted only in IDLE with stop low, stop wins when both arrive together.
//
// Precondition: CONV_HIGH_CYC + CONV_WAIT_CYC + READ_CYC <= 63.
module ads9327_conv_scheduler #(
   parameter int CONV_HIGH_CYC = 4,
   parameter int CONV_WAIT_CYC = 16,
   parameter int READ_CYC      = 32,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [2:0]       rate_sel,
`ifdef ADS9327_SCHED_BURST_EN
   input  logic [7:0]       burst_len,
`endif
   output logic             convst,
   output logic             rd_en,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             overrun,
   output logic [2:0]       dbg_state_o
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TICK = 3'd1,
      CONV      = 3'd2,
      GAP       = 3'd3,
      READ      = 3'd4
   } state_t;

   localparam logic [5:0] H_LAST = 6'(CONV_HIGH_CYC - 1);
   localparam logic [5:0] W_LAST = 6'(CONV_WAIT_CYC - 1);
   localparam logic [5:0] R_LAST = 6'(READ_CYC - 1);

   state_t           state_q, state_d;
   logic [5:0]       phase_q, phase_d;
   logic [12:0]      tick_cnt_q;
   logic [2:0]       rate_sel_q, rate_sel_d;
   logic             stop_pend_q, stop_pend_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic             overrun_q, overrun_d;
   logic             convst_q, rd_en_q, frame_done_q;
   logic             convst_d, rd_en_d, frame_done_d;
   logic [12:0]      tick_mask;
   logic             tick;
   logic             in_frame;
   logic             burst_done;

`ifdef ADS9327_SCHED_BURST_EN
   logic [7:0] burst_len_q, burst_len_d, burst_cnt_q, burst_cnt_d;
   // Last frame of a finite burst is the one completing burst_len frames.
   assign burst_done = (burst_len_q != 8'd0) && ((burst_cnt_q + 8'd1) == burst_len_q);
`else
   assign burst_done = 1'b0;
`endif

   // Mask of the low (rate_sel_q+6) bits; 4-bit sum avoids 3-bit wrap at 7.
   assign tick_mask = 13'((14'd1 << ({1'b0, rate_sel_q} + 4'd6)) - 14'd1);
   assign tick      = (tick_cnt_q & tick_mask) == 13'd0;
   assign in_frame  = (state_q == CONV) || (state_q == GAP) || (state_q == READ);

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      rate_sel_d   = rate_sel_q;
      stop_pend_d  = stop_pend_q;
      sample_cnt_d = sample_cnt_q;
      overrun_d    = overrun_q;
`ifdef ADS9327_SCHED_BURST_EN
      burst_len_d  = burst_len_q;
      burst_cnt_d  = burst_cnt_q;
`endif
      // A tick during a frame cannot be served later; it is only flagged.
      if (in_frame && tick) overrun_d = 1'b1;
      if (in_frame && stop) stop_pend_d = 1'b1;

      case (state_q)
         IDLE: begin
            stop_pend_d = 1'b0;
            if (start && !stop) begin
               state_d      = WAIT_TICK;
               overrun_d    = 1'b0;
               sample_cnt_d = '0;
               rate_sel_d   = rate_sel;
`ifdef ADS9327_SCHED_BURST_EN
               burst_len_d  = burst_len;
               burst_cnt_d  = 8'd0;
`endif
            end
         end
         WAIT_TICK: begin
            if (stop) begin
               state_d = IDLE;
            end else if (tick) begin
               state_d = CONV;
               phase_d = 6'd0;
            end
         end
         CONV: begin
            if (phase_q == H_LAST) begin
               state_d = GAP;
               phase_d = 6'd0;
            end else begin
               phase_d = phase_q + 6'd1;
            end
         end
         GAP: begin
            if (phase_q == W_LAST) begin
               state_d = READ;
               phase_d = 6'd0;
            end else begin
               phase_d = phase_q + 6'd1;
            end
         end
         READ: begin
            if (phase_q == R_LAST) begin
               sample_cnt_d = sample_cnt_q + CNT_W'(1);
               phase_d      = 6'd0;
`ifdef ADS9327_SCHED_BURST_EN
               burst_cnt_d  = burst_cnt_q + 8'd1;
`endif
               // A stop arriving on this very cycle also ends the run.
               if (stop_pend_q || stop || burst_done) state_d = IDLE;
               else                                   state_d = WAIT_TICK;
            end else begin
               phase_d = phase_q + 6'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Strobes decode the next state so they leave straight from flops.
      convst_d     = (state_d == CONV);
      rd_en_d      = (state_d == READ);
      frame_done_d = (state_d == READ) && (phase_d == R_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         phase_q      <= 6'd0;
         tick_cnt_q   <= 13'd0;
         rate_sel_q   <= 3'd0;
         stop_pend_q  <= 1'b0;
         sample_cnt_q <= '0;
         overrun_q    <= 1'b0;
         convst_q     <= 1'b0;
         rd_en_q      <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef ADS9327_SCHED_BURST_EN
         burst_len_q  <= 8'd0;
         burst_cnt_q  <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         tick_cnt_q   <= tick_cnt_q + 13'd1;
         rate_sel_q   <= rate_sel_d;
         stop_pend_q  <= stop_pend_d;
         sample_cnt_q <= sample_cnt_d;
         overrun_q    <= overrun_d;
         convst_q     <= convst_d;
         rd_en_q      <= rd_en_d;
         frame_done_q <= frame_done_d;
`ifdef ADS9327_SCHED_BURST_EN
         burst_len_q  <= burst_len_d;
         burst_cnt_q  <= burst_cnt_d;
`endif
      end
   end

   assign convst      = convst_q;
   assign rd_en       = rd_en_q;
   assign frame_done  = frame_done_q;
   assign busy        = (state_q != IDLE);
   assign sample_cnt  = sample_cnt_q;
   assign overrun     = overrun_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ads9327_conv_scheduler.sv
// Bench for ads9327_conv_scheduler. Two instances share the stimulus:
// u0 uses default timing (4/16/32), u1 uses 15/31/63 which cannot keep up
// with a 64-cycle period. Each output is compared every cycle with a
// frame-age reference model, plus directed checks of the listed scenarios.
module tb_ads9327_conv_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [2:0]  rate_sel = 3'd0;
   logic [7:0]  burst_len_tb = 8'd0;

   logic        convst_o [2];
   logic        rd_en_o [2];
   logic        busy_o [2];
   logic        frame_done_o [2];
   logic [15:0] sample_cnt_o [2];
   logic        overrun_o [2];
   logic [2:0]  dbg_o [2];

   always #5 clk = ~clk;

   ads9327_conv_scheduler u0 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .rate_sel(rate_sel),
`ifdef ADS9327_SCHED_BURST_EN
      .burst_len(burst_len_tb),
`endif
      .convst(convst_o[0]), .rd_en(rd_en_o[0]), .busy(busy_o[0]),
      .frame_done(frame_done_o[0]), .sample_cnt(sample_cnt_o[0]),
      .overrun(overrun_o[0]), .dbg_state_o(dbg_o[0])
   );

   ads9327_conv_scheduler #(
      .CONV_HIGH_CYC(15), .CONV_WAIT_CYC(31), .READ_CYC(63), .CNT_W(16)
   ) u1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .rate_sel(rate_sel),
`ifdef ADS9327_SCHED_BURST_EN
      .burst_len(burst_len_tb),
`endif
      .convst(convst_o[1]), .rd_en(rd_en_o[1]), .busy(busy_o[1]),
      .frame_done(frame_done_o[1]), .sample_cnt(sample_cnt_o[1]),
      .overrun(overrun_o[1]), .dbg_state_o(dbg_o[1])
   );

   // ---------------- reference model ----------------
   int hi_c [2] = '{4, 15};
   int wt_c [2] = '{16, 31};
   int rd_c [2] = '{32, 63};

   int unsigned tick_m = 0;
   bit act [2];
   int age [2];       // cycles since CONVST rose, -1 when no frame running
   bit pend [2];
   int rate [2];
   int cnt [2];
   bit ov [2];
   int blen [2];
   int frames [2];

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         int len;
         bit tk;
         len = hi_c[i] + wt_c[i] + rd_c[i];
         tk = (tick_m % (32'd1 << (rate[i] + 6))) == 0;
         if (rst) begin
            act[i] = 0; age[i] = -1; pend[i] = 0; rate[i] = 0;
            cnt[i] = 0; ov[i] = 0; blen[i] = 0; frames[i] = 0;
         end else if (!act[i]) begin
            pend[i] = 0;
            if (start && !stop) begin
               act[i] = 1; age[i] = -1; ov[i] = 0; cnt[i] = 0;
               rate[i] = int'(rate_sel); frames[i] = 0; blen[i] = int'(burst_len_tb);
            end
         end else if (age[i] < 0) begin
            if (stop) act[i] = 0;
            else if (tk) age[i] = 0;
         end else begin
            if (tk) ov[i] = 1;
            if (stop) pend[i] = 1;
            if (age[i] == len - 1) begin
               cnt[i] = (cnt[i] + 1) % 65536;
               frames[i]++;
               age[i] = -1;
               if (pend[i] || (blen[i] != 0 && frames[i] == blen[i])) begin
                  act[i] = 0;
                  pend[i] = 0;
               end
            end else begin
               age[i]++;
            end
         end
      end
      tick_m = rst ? 0 : (tick_m + 1) % 8192;
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         int hw;
         int len;
         hw = hi_c[i] + wt_c[i];
         len = hw + rd_c[i];
         check($sformatf("u%0d_convst", i), 32'(convst_o[i]), 32'(age[i] >= 0 && age[i] < hi_c[i]));
         check($sformatf("u%0d_rd_en", i), 32'(rd_en_o[i]), 32'(age[i] >= hw && age[i] < len));
         check($sformatf("u%0d_frame_done", i), 32'(frame_done_o[i]), 32'(age[i] == len - 1));
         check($sformatf("u%0d_busy", i), 32'(busy_o[i]), 32'(act[i]));
         check($sformatf("u%0d_sample_cnt", i), 32'(sample_cnt_o[i]), 32'(cnt[i]));
         check($sformatf("u%0d_overrun", i), 32'(overrun_o[i]), 32'(ov[i]));
      end
   endtask

   // ---------------- observation of u0 ----------------
   bit p37 = 0;
   int last_rise = -1;
   int first_rise = -1;
   int fd_cnt0 = 0;
   int last_fd_cyc = -1;
   int fall_cyc = -1;
   int rise_cnt [2] = '{0, 0};
   logic prev_conv [2] = '{1'b0, 1'b0};
   logic prev_rd0 = 1'b0;
   logic prev_busy0 = 1'b0;

   task automatic observe();
      for (int i = 0; i < 2; i++) begin
         if (convst_o[i] && !prev_conv[i]) rise_cnt[i]++;
      end
      if (convst_o[0] && !prev_conv[0]) begin
         if (p37 && last_rise >= 0) check("r37_conv_period", 32'(cyc - last_rise), 32'd64);
         last_rise = cyc;
         if (first_rise < 0) first_rise = cyc;
      end
      if (p37 && rd_en_o[0] && !prev_rd0) check("r37_rd_delay", 32'(cyc - last_rise), 32'd20);
      if (frame_done_o[0]) begin
         fd_cnt0++;
         last_fd_cyc = cyc;
      end
      if (prev_busy0 && !busy_o[0]) fall_cyc = cyc;
      prev_conv[0] = convst_o[0];
      prev_conv[1] = convst_o[1];
      prev_rd0 = rd_en_o[0];
      prev_busy0 = busy_o[0];
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc1();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_all();
      observe();
   endtask

   task automatic run(input int n);
      repeat (n) cyc1();
   endtask

   task automatic pulse_start(input logic [2:0] r);
      rate_sel = r;
      start = 1'b1;
      cyc1();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      cyc1();
      stop = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      cyc1();
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while ((act[0] || act[1]) && k < bound) begin
         cyc1();
         k++;
      end
      check("idle_u0_busy", 32'(busy_o[0]), 32'd0);
      check("idle_u1_busy", 32'(busy_o[1]), 32'd0);
   endtask

   initial begin
      int k;
      int rst_cyc;
      // Reset
      run(3);
      rst = 1'b0;
      check("reset_busy", 32'(busy_o[0]), 32'd0);
      check("reset_cnt", 32'(sample_cnt_o[0]), 32'd0);
      run(5);

      // Continuous conversions at rate 0; rate_sel wiggles are ignored
      p37 = 1; last_rise = -1;
      pulse_start(3'd0);
      for (int i = 0; i < 320; i++) begin
         rate_sel = 3'($urandom_range(0, 7));
         cyc1();
      end
      p37 = 0;
      check("r37_no_overrun", 32'(overrun_o[0]), 32'd0);
      pulse_stop();
      wait_idle(400);

      // Stop during READ of frame 3
      fd_cnt0 = 0;
      pulse_start(3'd0);
      k = 0;
      while (!(frames[0] == 2 && age[0] >= hi_c[0] + wt_c[0]) && k < 1000) begin
         cyc1();
         k++;
      end
      check("r38_in_read", 32'(rd_en_o[0]), 32'd1);
      pulse_stop();
      wait_idle(400);
      check("r38_cnt", 32'(sample_cnt_o[0]), 32'd3);
      check("r38_fd_pulses", 32'(fd_cnt0), 32'd3);
      check("r38_busy_fall", 32'(fall_cyc - last_fd_cyc), 32'd1);

      // Start and stop in the same idle cycle
      rise_cnt[0] = 0; rise_cnt[1] = 0;
      start = 1'b1; stop = 1'b1;
      cyc1();
      start = 1'b0; stop = 1'b0;
      run(150);
      check("r39_busy", 32'(busy_o[0]), 32'd0);
      check("r39_rises_u0", 32'(rise_cnt[0]), 32'd0);
      check("r39_rises_u1", 32'(rise_cnt[1]), 32'd0);

      // Overrun on the slow instance, sticky until the next start
      pulse_start(3'd0);
      k = 0;
      while (!ov[1] && k < 400) begin
         cyc1();
         k++;
      end
      check("r40_ov_set", 32'(overrun_o[1]), 32'd1);
      check("r40_fast_no_ov", 32'(overrun_o[0]), 32'd0);
      pulse_stop();
      wait_idle(400);
      run(20);
      check("r40_sticky", 32'(overrun_o[1]), 32'd1);
      pulse_start(3'd1);
      check("r40_clear_on_start", 32'(overrun_o[1]), 32'd0);

      // Reset pulse during GAP
      k = 0;
      while (!(age[0] >= hi_c[0] && age[0] < hi_c[0] + wt_c[0]) && k < 600) begin
         cyc1();
         k++;
      end
      pulse_rst();
      rst_cyc = cyc;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("r41_u%0d_convst", i), 32'(convst_o[i]), 32'd0);
         check($sformatf("r41_u%0d_rd_en", i), 32'(rd_en_o[i]), 32'd0);
         check($sformatf("r41_u%0d_busy", i), 32'(busy_o[i]), 32'd0);
         check($sformatf("r41_u%0d_cnt", i), 32'(sample_cnt_o[i]), 32'd0);
      end
      first_rise = -1; last_rise = -1; p37 = 1;
      pulse_start(3'd0);
      run(300);
      p37 = 0;
      check("r41_first_rise", 32'(first_rise - rst_cyc), 32'd65);
      pulse_stop();
      wait_idle(400);

      // Randomized runs
      for (int it = 0; it < 20; it++) begin
         int n;
         pulse_start(3'($urandom_range(0, 2)));
         n = $urandom_range(50, 500);
         for (int j = 0; j < n; j++) begin
            rate_sel = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 15) == 0);
            stop = ($urandom_range(0, 63) == 0);
            cyc1();
            start = 1'b0;
            stop = 1'b0;
         end
         if ($urandom_range(0, 7) == 0) pulse_rst();
         else pulse_stop();
         wait_idle(600);
      end

`ifdef ADS9327_SCHED_BURST_EN
      // Finite burst of 5 frames
      burst_len_tb = 8'd5;
      fd_cnt0 = 0;
      pulse_start(3'd0);
      burst_len_tb = 8'd0;
      wait_idle(2000);
      check("r42_fd_pulses", 32'(fd_cnt0), 32'd5);
      check("r42_cnt", 32'(sample_cnt_o[0]), 32'd5);
      check("r42_cnt_u1", 32'(sample_cnt_o[1]), 32'd5);
`endif

      run(10);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
